si_da_decode: RTL and testbench

SI_DA_DECODE -- requirements
Module: si_da_decode

---
 rtl/si_da_decode.sv | 145 ++++++++++++++
 tb/tb_si_da_decode.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/si_da_decode.sv
// Destination-address decoder for a byte-wide receive stream: folds the six DA
// bytes into a CRC hash index and unicast/multicast/broadcast/pause flags.
module si_da_decode (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [7:0]  rxd_i,
  input  logic        rxdv_i,
  input  logic        sof_i,
  input  logic        eof_i,
  input  logic [47:0] stadr_i,
  output logic [6:0]  hashv_o,
  output logic        hashe_o,
  output logic        ucad_o,
  output logic        mcad_o,
  output logic        bcad_o,
  output logic        mcadp_o,
  output logic        dat_o
);

  typedef enum logic [1:0] {IDLE, DA, BODY} state_t;

  localparam logic [31:0] CRC_POLY  = 32'h04C1_1DB7;
  localparam logic [47:0] PAUSE_ADR = 48'h0100_00C2_8001;  // byte 0 in [7:0]

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx, idx;
  logic [31:0] crc, crc_nx, crc_byte;
  logic        bc_m, uc_m, mp_m, mc_r;
  logic        bc_nx, uc_nx, mp_nx, mc_nx;
  logic        hash_fire;
  logic [7:0]  st_byte, mp_byte;

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [47:0] v, input logic [2:0] k);
    logic [7:0] b;
    case (k)
      3'd0:    b = v[7:0];
      3'd1:    b = v[15:8];
      3'd2:    b = v[23:16];
      3'd3:    b = v[31:24];
      3'd4:    b = v[39:32];
      default: b = v[47:40];
    endcase
    return b;
  endfunction

  // A SOF byte is always DA byte 0 and seeds the CRC, whatever state we were in.
  always_comb begin
    idx      = sof_i ? 3'd0 : cnt;
    st_byte  = byte_sel(stadr_i, idx);
    mp_byte  = byte_sel(PAUSE_ADR, idx);
    crc_byte = crc_step(sof_i ? 32'hFFFF_FFFF : crc, rxd_i);
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    crc_nx    = crc;
    bc_nx     = bc_m;
    uc_nx     = uc_m;
    mp_nx     = mp_m;
    mc_nx     = mc_r;
    hash_fire = 1'b0;
    if (rxdv_i) begin
      if (sof_i) begin
        crc_nx   = crc_byte;
        bc_nx    = (rxd_i == 8'hFF);
        uc_nx    = (rxd_i == st_byte);
        mp_nx    = (rxd_i == mp_byte);
        mc_nx    = rxd_i[0];
        cnt_nx   = eof_i ? 3'd0 : 3'd1;
        state_nx = eof_i ? IDLE : DA;
      end else begin
        case (state)
          DA: begin
            crc_nx = crc_byte;
            bc_nx  = bc_m & (rxd_i == 8'hFF);
            uc_nx  = uc_m & (rxd_i == st_byte);
            mp_nx  = mp_m & (rxd_i == mp_byte);
            if (cnt == 3'd5) begin
              hash_fire = 1'b1;
              cnt_nx    = 3'd0;
              state_nx  = eof_i ? IDLE : BODY;
            end else if (eof_i) begin
              cnt_nx   = 3'd0;
              state_nx = IDLE;
            end else begin
              cnt_nx = cnt + 3'd1;
            end
          end
          BODY: if (eof_i) state_nx = IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      crc     <= 32'hFFFF_FFFF;
      bc_m    <= 1'b0;
      uc_m    <= 1'b0;
      mp_m    <= 1'b0;
      mc_r    <= 1'b0;
      hashv_o <= 7'd0;
      hashe_o <= 1'b0;
      ucad_o  <= 1'b0;
      mcad_o  <= 1'b0;
      bcad_o  <= 1'b0;
      mcadp_o <= 1'b0;
      dat_o   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      crc     <= crc_nx;
      bc_m    <= bc_nx;
      uc_m    <= uc_nx;
      mp_m    <= mp_nx;
      mc_r    <= mc_nx;
      hashe_o <= hash_fire;
      // sof+eof on one byte lands in IDLE but still shows a one-cycle dat_o pulse
      dat_o   <= (state_nx != IDLE) | (rxdv_i & sof_i);
      if (hash_fire) begin
        hashv_o <= crc_nx[31:25];
        ucad_o  <= uc_nx;
        mcad_o  <= mc_r;
        bcad_o  <= bc_nx;
        mcadp_o <= mp_nx;
      end
    end
  end

endmodule

// File: tb/tb_si_da_decode.sv
// Directed and randomised-DA bench for si_da_decode with a reference hash model.
module tb_si_da_decode;

  localparam logic [47:0] PAUSE = 48'h0100_00C2_8001;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] UCAST = 48'h5544_3322_1100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        rxdv = 1'b0, sof = 1'b0, eof = 1'b0;
  logic [47:0] stadr = 48'h0;
  logic [6:0]  hashv;
  logic        hashe, ucad, mcad, bcad, mcadp, dat;

  int n_vec = 0;
  int n_bad = 0;
  int hcnt  = 0;

  si_da_decode dut (
    .clk_i(clk), .reset_ni(reset_n), .rxd_i(rxd), .rxdv_i(rxdv), .sof_i(sof),
    .eof_i(eof), .stadr_i(stadr), .hashv_o(hashv), .hashe_o(hashe),
    .ucad_o(ucad), .mcad_o(mcad), .bcad_o(bcad), .mcadp_o(mcadp), .dat_o(dat)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (hashe) hcnt++;

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_hash(input logic [47:0] da);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int b = 0; b < 48; b++) begin
      fb = c[31] ^ da[b];
      c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
    end
    return c[31:25];
  endfunction

  task automatic send(input logic [7:0] d, input logic s, input logic e);
    rxd = d; rxdv = 1'b1; sof = s; eof = e;
    @(posedge clk);
    #1;
    rxdv = 1'b0; sof = 1'b0; eof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_da(input logic [47:0] da, input logic eof5);
    for (int i = 0; i < 6; i++) send(da[8*i +: 8], i == 0, eof5 && i == 5);
  endtask

  task automatic check_out(input string tag, input logic [6:0] h, input logic u,
                           input logic m, input logic b, input logic p);
    check_eq({tag, ".hashv"}, 48'(hashv), 48'(h));
    check_eq({tag, ".ucad"},  48'(ucad),  48'(u));
    check_eq({tag, ".mcad"},  48'(mcad),  48'(m));
    check_eq({tag, ".bcad"},  48'(bcad),  48'(b));
    check_eq({tag, ".mcadp"}, 48'(mcadp), 48'(p));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, ".hashe"}, 48'(hashe), 48'd0);
    check_eq({tag, ".dat"},   48'(dat),   48'd0);
    check_out(tag, 7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int          h0;
    logic [47:0] da;
    logic [6:0]  hp;

    // reset state
    idle(2);
    check_zero("reset");
    reset_n = 1'b1;
    stadr   = UCAST;
    idle(1);

    // broadcast, 64 bytes, continuous
    h0 = hcnt;
    for (int i = 0; i < 64; i++) begin
      send(8'hFF, i == 0, i == 63);
      if (i == 0) check_eq("bc.dat_rise", 48'(dat), 48'd1);
      if (i == 4) check_eq("bc.hashe_early", 48'(hashe), 48'd0);
      if (i == 5) begin
        check_eq("bc.hashe", 48'(hashe), 48'd1);
        check_out("bc", ref_hash(BCAST), 1'b0, 1'b1, 1'b1, 1'b0);
      end
      if (i == 6) check_eq("bc.hashe_one", 48'(hashe), 48'd0);
    end
    check_eq("bc.dat_fall", 48'(dat), 48'd0);
    check_eq("bc.hcnt", 48'(hcnt - h0), 48'd1);

    // unicast with rxdv gaps
    h0 = hcnt;
    for (int i = 0; i < 6; i++) begin
      send(UCAST[8*i +: 8], i == 0, 1'b0);
      if (i == 5) begin
        check_eq("uc.hashe", 48'(hashe), 48'd1);
        check_out("uc", ref_hash(UCAST), 1'b1, 1'b0, 1'b0, 1'b0);
      end
      idle($urandom_range(1, 3));
    end
    check_eq("uc.hold", 48'(ucad), 48'd1);
    send(8'hA5, 1'b0, 1'b0);
    idle(2);
    send(8'h5A, 1'b0, 1'b1);
    check_eq("uc.dat_fall", 48'(dat), 48'd0);
    check_eq("uc.hcnt", 48'(hcnt - h0), 48'd1);

    // pause address, eof on DA byte 5
    send_da(PAUSE, 1'b1);
    hp = ref_hash(PAUSE);
    check_eq("pa.hashe", 48'(hashe), 48'd1);
    check_eq("pa.dat", 48'(dat), 48'd0);
    check_out("pa", hp, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(1);

    // runt with eof on byte 3
    h0 = hcnt;
    send(8'hFF, 1'b1, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b1);
    check_eq("runt.dat", 48'(dat), 48'd0);
    idle(3);
    check_eq("runt.hcnt", 48'(hcnt - h0), 48'd0);
    check_out("runt", hp, 1'b0, 1'b1, 1'b0, 1'b1);
    send_da(BCAST, 1'b1);
    check_eq("after_runt.hashe", 48'(hashe), 48'd1);
    check_out("after_runt", ref_hash(BCAST), 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1);

    // sof and eof on one byte
    h0 = hcnt;
    send(8'h12, 1'b1, 1'b1);
    check_eq("se.dat_hi", 48'(dat), 48'd1);
    idle(1);
    check_eq("se.dat_lo", 48'(dat), 48'd0);
    check_eq("se.hcnt", 48'(hcnt - h0), 48'd0);

    // sof reasserted on byte 9 restarts the frame
    for (int i = 0; i < 9; i++) send(PAUSE[8*(i % 6) +: 8], i == 0, 1'b0);
    h0 = hcnt;
    for (int i = 0; i < 6; i++) begin
      send(UCAST[8*i +: 8], i == 0, 1'b0);
      if (i == 0) check_eq("rs.dat", 48'(dat), 48'd1);
      if (i == 4) check_eq("rs.hashe_early", 48'(hashe), 48'd0);
    end
    check_eq("rs.hashe", 48'(hashe), 48'd1);
    check_out("rs", ref_hash(UCAST), 1'b1, 1'b0, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b1);
    check_eq("rs.hcnt", 48'(hcnt - h0), 48'd1);

    // reset pulsed on byte 2 of a further frame
    h0 = hcnt;
    send(8'hFF, 1'b1, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    rxd = 8'hFF; rxdv = 1'b1;
    reset_n = 1'b0;
    #1;
    check_zero("rst_mid");
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    rxdv = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) send(8'hFF, 1'b0, 1'b0);
    check_eq("rst.dat", 48'(dat), 48'd0);
    check_eq("rst.hcnt", 48'(hcnt - h0), 48'd0);
    send_da(PAUSE, 1'b1);
    check_eq("after_rst.hashe", 48'(hashe), 48'd1);
    check_out("after_rst", hp, 1'b0, 1'b1, 1'b0, 1'b1);

    // random DAs against the reference model
    stadr = {$urandom(), $urandom()} & 48'hFEFF_FFFF_FFFF;
    for (int n = 0; n < 10000; n++) begin
      case ($urandom_range(0, 7))
        0:       da = BCAST;
        1:       da = stadr;
        2:       da = PAUSE;
        default: da = {$urandom(), $urandom()};
      endcase
      send_da(da, 1'b1);
      check_eq("rnd.hashe", 48'(hashe), 48'd1);
      check_out("rnd", ref_hash(da), da == stadr, da[0], da == BCAST, da == PAUSE);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
